// File: rtl/snake_mover.sv
// snake_mover: movement stage of the snake display path.
// Holds the snake body as a circular buffer of cell positions. On each game
// tick it computes the new head cell and scans the body for self-collision,
// one segment per cycle, from tail to head. It then commits the move and
// tells the bitmap generator which cell was gained and which was vacated.
// Cell encoding: pos[7:4] = row, pos[3:0] = column.
module snake_mover #(
  parameter int ROWS     = 8,
  parameter int COLS     = 16,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [1:0] dir_req,
  input  logic [7:0] food_pos,
  output logic [7:0] head_pos,
  output logic [7:0] tail_pos,
  output logic       move_valid,
  output logic       grow,
  output logic [5:0] length,
  output logic       busy,
  output logic       game_over
);

  localparam int         PW        = $clog2(MAX_LEN);
  localparam logic [3:0] ROW_MAX   = 4'(ROWS - 1);
  localparam logic [3:0] COL_MAX   = 4'(COLS - 1);
  localparam logic [7:0] INIT_HEAD = {4'(INIT_LEN - 1), 4'h0};
  localparam logic [5:0] LEN_MAX   = 6'(MAX_LEN);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    COMMIT,
    DEAD
  } state_t;

  state_t          state;
  logic [1:0]      dir;
  logic [7:0]      body [MAX_LEN];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [7:0]      next_head;
  logic            eat;
  logic            hit;
  logic [5:0]      scan_cnt;

  logic [1:0]      dir_eff;
  logic [7:0]      cand_head;
  logic [PW-1:0]   scan_addr;
  logic [PW-1:0]   head_ptr_nxt;
  logic            seg_match;

  // Neighbouring cell in the given direction, wrapping at the board edges.
  function automatic logic [7:0] step_cell(input logic [7:0] pos,
                                           input logic [1:0] dir_in);
    logic [3:0] r;
    logic [3:0] c;
    r = pos[7:4];
    c = pos[3:0];
    case (dir_in)
      DIR_UP:    r = (r == 4'd0)    ? ROW_MAX : r - 4'd1;
      DIR_RIGHT: c = (c == COL_MAX) ? 4'd0    : c + 4'd1;
      DIR_DOWN:  r = (r == ROW_MAX) ? 4'd0    : r + 4'd1;
      default:   c = (c == 4'd0)    ? COL_MAX : c - 4'd1;
    endcase
    return {r, c};
  endfunction

  // A reversal request would fold the head straight back into the neck, so it
  // is ignored and the snake keeps going the way it was heading.
  assign dir_eff      = (dir_req == (dir ^ 2'b10)) ? dir : dir_req;
  assign cand_head    = step_cell(head_pos, dir_eff);
  assign scan_addr    = tail_ptr + scan_cnt[PW-1:0];
  assign head_ptr_nxt = head_ptr + PW'(1);
  // Without food the tail cell is vacated by this very move, so the head may
  // legally enter it; that first (tail) entry is skipped in the scan.
  assign seg_match    = (body[scan_addr] == next_head) &&
                        !((scan_cnt == 6'd0) && !eat);

  // Game-step FSM together with the body buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dir        <= DIR_DOWN;
      head_ptr   <= PW'(INIT_LEN - 1);
      tail_ptr   <= '0;
      head_pos   <= INIT_HEAD;
      tail_pos   <= 8'h00;
      length     <= 6'(INIT_LEN);
      move_valid <= 1'b0;
      grow       <= 1'b0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
      next_head  <= INIT_HEAD;
      eat        <= 1'b0;
      hit        <= 1'b0;
      scan_cnt   <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        body[i] <= (i < INIT_LEN) ? {4'(i), 4'h0} : 8'h00;
      end
    end else begin
      move_valid <= 1'b0;
      grow       <= 1'b0;
      case (state)
        IDLE: begin
          if (step) begin
            dir       <= dir_eff;
            next_head <= cand_head;
            eat       <= (cand_head == food_pos) && (length < LEN_MAX);
            hit       <= 1'b0;
            scan_cnt  <= '0;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          hit      <= hit | seg_match;
          scan_cnt <= scan_cnt + 6'd1;
          if (scan_cnt == length - 6'd1) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          busy <= 1'b0;
          if (hit) begin
            game_over <= 1'b1;
            state     <= DEAD;
          end else begin
            body[head_ptr_nxt] <= next_head;
            head_ptr           <= head_ptr_nxt;
            head_pos           <= next_head;
            move_valid         <= 1'b1;
            grow               <= eat;
            if (eat) begin
              length <= length + 6'd1;
            end else begin
              tail_pos <= body[tail_ptr];
              tail_ptr <= tail_ptr + PW'(1);
            end
            state <= IDLE;
          end
        end
        DEAD: begin
          state <= DEAD;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_mover.sv
// tb_snake_mover: directed table of moves, multi-cycle corner sequences and
// randomized moves scored against a queue-based model of the snake.
module tb_snake_mover;

  localparam int ROWS     = 8;
  localparam int COLS     = 16;
  localparam int MAX_LEN  = 32;
  localparam int INIT_LEN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic [1:0] dir_req;
  logic [7:0] food_pos;
  logic [7:0] head_pos;
  logic [7:0] tail_pos;
  logic       move_valid;
  logic       grow;
  logic [5:0] length;
  logic       busy;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  snake_mover #(
    .ROWS(ROWS), .COLS(COLS), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .dir_req(dir_req), .food_pos(food_pos),
    .head_pos(head_pos), .tail_pos(tail_pos), .move_valid(move_valid),
    .grow(grow), .length(length), .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dir;
    logic [7:0] food;
    logic [7:0] head;
    logic [7:0] tail;
    logic       grw;
    logic [5:0] len;
    logic       over;
  } vec_t;

  vec_t vecs[14];

  // Reference model: body as a queue, tail at index 0, head at the back.
  logic [7:0] body[$];
  int         mdir;
  logic [7:0] mtail;
  bit         mdead;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] mnext(input logic [7:0] p, input int d);
    int r;
    int c;
    r = int'(p[7:4]);
    c = int'(p[3:0]);
    case (d)
      0:       r = (r + ROWS - 1) % ROWS;
      1:       c = (c + 1) % COLS;
      2:       r = (r + 1) % ROWS;
      default: c = (c + COLS - 1) % COLS;
    endcase
    return {4'(r), 4'(c)};
  endfunction

  task automatic model_reset();
    body.delete();
    for (int i = 0; i < INIT_LEN; i++) body.push_back({4'(i), 4'h0});
    mdir  = 2;
    mtail = 8'h00;
    mdead = 0;
  endtask

  task automatic model_step(input logic [1:0] d, input logic [7:0] f,
                            output logic [7:0] eh, output logic [7:0] et,
                            output logic eg, output logic [5:0] el,
                            output logic eo, output int elat);
    int         eff;
    logic [7:0] nh;
    bit         eat_m;
    bit         hit_m;
    elat  = body.size() + 2;
    eff   = (int'(d) == (mdir ^ 2)) ? mdir : int'(d);
    nh    = mnext(body[body.size()-1], eff);
    eat_m = (nh == f) && (body.size() < MAX_LEN);
    hit_m = 0;
    for (int i = (eat_m ? 0 : 1); i < body.size(); i++) begin
      if (body[i] == nh) hit_m = 1;
    end
    mdir = eff;
    if (hit_m) begin
      mdead = 1;
      eg    = 1'b0;
    end else begin
      if (!eat_m) mtail = body.pop_front();
      body.push_back(nh);
      eg = eat_m;
    end
    eh = body[body.size()-1];
    et = mtail;
    el = 6'(body.size());
    eo = mdead;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    step = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One step pulse; waits (bounded) for the move pulse or the collision flag.
  task automatic apply_step(input logic [1:0] d, input logic [7:0] f,
                            output int lat, output logic b0, output logic mv,
                            output logic gr, output logic [7:0] hp,
                            output logic [7:0] tp, output logic [5:0] ln,
                            output logic go);
    dir_req  = d;
    food_pos = f;
    step     = 1'b1;
    @(posedge clk); #1;
    step     = 1'b0;
    food_pos = 8'hFF;
    b0       = busy;
    lat      = 1;
    while (!(move_valid || game_over) && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    mv = move_valid;
    gr = grow;
    hp = head_pos;
    tp = tail_pos;
    ln = length;
    go = game_over;
    @(posedge clk); #1;
    chk("mv_pulse_end", 8'(move_valid), 8'h00);
    chk("grow_pulse_end", 8'(grow), 8'h00);
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] d,
                               input logic [7:0] f, input logic [7:0] eh,
                               input logic [7:0] et, input logic eg,
                               input logic [5:0] el, input logic eo,
                               input int elat);
    int         lat;
    logic       b0;
    logic       mv;
    logic       gr;
    logic [7:0] hp;
    logic [7:0] tp;
    logic [5:0] ln;
    logic       go;
    apply_step(d, f, lat, b0, mv, gr, hp, tp, ln, go);
    chk({tag, "_latency"}, 8'(lat), 8'(elat));
    chk({tag, "_busy"}, 8'(b0), 8'h01);
    chk({tag, "_move_valid"}, 8'(mv), 8'(!eo));
    chk({tag, "_grow"}, 8'(gr), 8'(eg));
    chk({tag, "_head"}, hp, eh);
    chk({tag, "_tail"}, tp, et);
    chk({tag, "_length"}, 8'(ln), 8'(el));
    chk({tag, "_game_over"}, 8'(go), 8'(eo));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cur_len;
    int         seen;
    logic [1:0] d;
    logic [7:0] f;
    logic [7:0] eh;
    logic [7:0] et;
    logic       eg;
    logic [5:0] el;
    logic       eo;
    int         elat;
    int         eff;

    rst      = 1'b0;
    step     = 1'b0;
    dir_req  = 2'b10;
    food_pos = 8'hFF;

    //                dir    food   head   tail   grow  len    over
    vecs[0]  = '{2'd2, 8'hFF, 8'h30, 8'h00, 1'b0, 6'd3, 1'b0};
    vecs[1]  = '{2'd2, 8'hFF, 8'h40, 8'h10, 1'b0, 6'd3, 1'b0};
    vecs[2]  = '{2'd2, 8'hFF, 8'h50, 8'h20, 1'b0, 6'd3, 1'b0};
    vecs[3]  = '{2'd2, 8'hFF, 8'h60, 8'h30, 1'b0, 6'd3, 1'b0};
    vecs[4]  = '{2'd2, 8'hFF, 8'h70, 8'h40, 1'b0, 6'd3, 1'b0};
    vecs[5]  = '{2'd2, 8'hFF, 8'h00, 8'h50, 1'b0, 6'd3, 1'b0};
    vecs[6]  = '{2'd0, 8'hFF, 8'h10, 8'h60, 1'b0, 6'd3, 1'b0};
    vecs[7]  = '{2'd1, 8'hFF, 8'h11, 8'h70, 1'b0, 6'd3, 1'b0};
    vecs[8]  = '{2'd1, 8'h12, 8'h12, 8'h70, 1'b1, 6'd4, 1'b0};
    vecs[9]  = '{2'd1, 8'hFF, 8'h13, 8'h00, 1'b0, 6'd4, 1'b0};
    vecs[10] = '{2'd1, 8'h14, 8'h14, 8'h00, 1'b1, 6'd5, 1'b0};
    vecs[11] = '{2'd2, 8'hFF, 8'h24, 8'h10, 1'b0, 6'd5, 1'b0};
    vecs[12] = '{2'd3, 8'hFF, 8'h23, 8'h11, 1'b0, 6'd5, 1'b0};
    vecs[13] = '{2'd0, 8'hFF, 8'h23, 8'h11, 1'b0, 6'd5, 1'b1};

    // Reset state
    do_reset();
    chk("rst_head", head_pos, 8'h20);
    chk("rst_tail", tail_pos, 8'h00);
    chk("rst_length", 8'(length), 8'd3);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_game_over", 8'(game_over), 8'h00);
    chk("rst_move_valid", 8'(move_valid), 8'h00);
    chk("rst_grow", 8'(grow), 8'h00);

    // Directed table: wrap, reversal, turn, eat, collision
    cur_len = INIT_LEN;
    for (int i = 0; i < 14; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].dir, vecs[i].food,
                    vecs[i].head, vecs[i].tail, vecs[i].grw, vecs[i].len,
                    vecs[i].over, cur_len + 2);
      cur_len = int'(vecs[i].len);
    end

    // Steps while dead are ignored and outputs stay frozen
    seen    = 0;
    dir_req = 2'b10;
    for (int k = 0; k < 20; k++) begin
      step = (k % 5 == 0);
      @(posedge clk); #1;
      if (move_valid || busy) seen++;
    end
    step = 1'b0;
    chk("dead_ignored", 8'(seen), 8'h00);
    chk("dead_head", head_pos, 8'h23);
    chk("dead_game_over", 8'(game_over), 8'h01);
    do_reset();
    chk("dead_rst_head", head_pos, 8'h20);
    chk("dead_rst_game_over", 8'(game_over), 8'h00);
    chk("dead_rst_length", 8'(length), 8'd3);

    // Step pulsed again during CHECK is dropped
    dir_req = 2'b10;
    step    = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    @(posedge clk); #1;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (move_valid) seen++;
      @(posedge clk); #1;
    end
    chk("drop_mv_count", 8'(seen), 8'h01);
    chk("drop_head", head_pos, 8'h30);
    chk("drop_busy", 8'(busy), 8'h00);

    // rst in the middle of CHECK aborts the step
    do_reset();
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    @(posedge clk); #1;
    chk("midchk_busy", 8'(busy), 8'h01);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 8'(busy), 8'h00);
    chk("midrst_head", head_pos, 8'h20);
    chk("midrst_length", 8'(length), 8'd3);
    chk("midrst_move_valid", 8'(move_valid), 8'h00);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (move_valid) seen++;
      @(posedge clk); #1;
    end
    chk("midrst_no_move", 8'(seen), 8'h00);
    run_and_check("after_midrst", 2'b10, 8'hFF, 8'h30, 8'h00, 1'b0, 6'd3, 1'b0, 5);

    // Randomized moves against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 250; n++) begin
      if (mdead) begin
        do_reset();
        model_reset();
      end
      d   = 2'($urandom_range(0, 3));
      eff = (int'(d) == (mdir ^ 2)) ? mdir : int'(d);
      if ($urandom_range(0, 1) == 1) f = mnext(body[body.size()-1], eff);
      else f = 8'($urandom);
      model_step(d, f, eh, et, eg, el, eo, elat);
      run_and_check($sformatf("rnd%0d", n), d, f, eh, et, eg, el, eo, elat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
